// File: rtl/door_warn_pkg.sv
// Shared definitions for the door_warn_monitor slice: per-channel state
// encoding and the counter width helper.
package door_warn_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        CLOSED    = 3'd0,
        DEBOUNCE  = 3'd1,
        OPEN_WAIT = 3'd2,
        WARN      = 3'd3,
        MUTED     = 3'd4
    } chan_state_t;

    // Width able to hold the larger of the two count limits.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/door_warn_channel.sv
// One door channel: open debounce, hold-open delay, warning, mute and
// close debounce. Publishes the next-state warning bit for registering
// at the top level.
// Optional build macro: DOOR_WARN_STICKY_EN (warning survives closing,
// only an acknowledge leaves WARN).
module door_warn_channel
    import door_warn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WARN_DELAY      = 100
) (
    input  logic clock,
    input  logic reset,
    input  logic door_open,
    input  logic warn_ack,
    output logic warn_next
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, WARN_DELAY);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] WD_LAST = CW'(WARN_DELAY - 1);

    chan_state_t   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] cnt_close;
    logic          close_done;

    // Close debounce shared by WARN and MUTED: count consecutive low samples.
    always_comb begin
        cnt_close  = door_open ? '0 : cnt + 1'b1;
        close_done = !door_open && (cnt == DB_LAST);
    end

    // Next-state and counter update.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            CLOSED: begin
                if (door_open) begin
                    state_n = DEBOUNCE;
                    cnt_n   = CW'(1);
                end else begin
                    cnt_n = '0;
                end
            end
            DEBOUNCE: begin
                if (!door_open) begin
                    state_n = CLOSED;
                    cnt_n   = '0;
                end else if (cnt == DB_LAST) begin
                    state_n = OPEN_WAIT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            OPEN_WAIT: begin
                if (!door_open) begin
                    state_n = CLOSED;
                    cnt_n   = '0;
                end else if (cnt == WD_LAST) begin
                    state_n = WARN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WARN: begin
`ifdef DOOR_WARN_STICKY_EN
                cnt_n = '0;
                if (warn_ack) begin
                    state_n = door_open ? MUTED : CLOSED;
                end
`else
                // A completed close wins over a same-edge acknowledge.
                if (close_done) begin
                    state_n = CLOSED;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_close;
                    if (warn_ack) begin
                        state_n = MUTED;
                    end
                end
`endif
            end
            MUTED: begin
                if (close_done) begin
                    state_n = CLOSED;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_close;
                end
            end
            default: begin
                state_n = CLOSED;
                cnt_n   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= CLOSED;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    assign warn_next = (state_n == WARN);

endmodule

// File: rtl/door_warn_monitor.sv
// Multi-door open warning monitor: NUM_DOORS independent channels plus
// registered per-door warnings, aggregate warning and active-warning count.
// Optional build macro: DOOR_WARN_STICKY_EN (passed through to channels).
module door_warn_monitor
    import door_warn_pkg::*;
#(
    parameter int NUM_DOORS       = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WARN_DELAY      = 100
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_DOORS-1:0]           door_open,
    input  logic [NUM_DOORS-1:0]           warn_ack,
    output logic [NUM_DOORS-1:0]           warn_door_open,
    output logic                           warn_any,
    output logic [$clog2(NUM_DOORS+1)-1:0] warn_count
);

    localparam int CNTW = $clog2(NUM_DOORS + 1);

    logic [NUM_DOORS-1:0] warn_next;
    logic [CNTW-1:0]      count_next;

    for (genvar g = 0; g < NUM_DOORS; g++) begin : g_chan
        door_warn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .WARN_DELAY      (WARN_DELAY)
        ) u_chan (
            .clock     (clock),
            .reset     (reset),
            .door_open (door_open[g]),
            .warn_ack  (warn_ack[g]),
            .warn_next (warn_next[g])
        );
    end

    // Population count of next-state warnings.
    always_comb begin
        count_next = '0;
        for (int unsigned i = 0; i < NUM_DOORS; i++) begin
            count_next = count_next + CNTW'(warn_next[i]);
        end
    end

    // Output registers, all updated on the same edge as the channel states.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            warn_door_open <= '0;
            warn_any       <= 1'b0;
            warn_count     <= '0;
        end else begin
            warn_door_open <= warn_next;
            warn_any       <= |warn_next;
            warn_count     <= count_next;
        end
    end

endmodule

// File: tb/tb_door_warn_monitor.sv
// Scoreboard bench for door_warn_monitor: a driver steps a run-length
// reference model each edge and queues the expected outputs; a monitor
// pops and compares after every edge.
module tb_door_warn_monitor;

    localparam int N  = 4;
    localparam int DB = 4;
    localparam int WD = 100;
    localparam int CW = $clog2(N + 1);

    logic          clock = 1'b0;
    logic          reset;
    logic [N-1:0]  door_open;
    logic [N-1:0]  warn_ack;
    logic [N-1:0]  warn_door_open;
    logic          warn_any;
    logic [CW-1:0] warn_count;

    always #5 clock = ~clock;

    door_warn_monitor #(
        .NUM_DOORS       (N),
        .DEBOUNCE_CYCLES (DB),
        .WARN_DELAY      (WD)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .door_open      (door_open),
        .warn_ack       (warn_ack),
        .warn_door_open (warn_door_open),
        .warn_any       (warn_any),
        .warn_count     (warn_count)
    );

    typedef struct packed {
        logic [N-1:0]  w;
        logic          a;
        logic [CW-1:0] c;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: consecutive-open run, consecutive-close run,
    // warning-raised flag and muted flag per door.
    int open_run[N];
    int close_run[N];
    bit active[N];
    bit muted[N];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            open_run[i]  = 0;
            close_run[i] = 0;
            active[i]    = 1'b0;
            muted[i]     = 1'b0;
        end
    endfunction

    function automatic exp_t model_step(input logic [N-1:0] dv, input logic [N-1:0] av);
        exp_t e;
        int   cnt;
        cnt = 0;
        e   = '0;
        for (int i = 0; i < N; i++) begin
            if (!active[i]) begin
                open_run[i] = dv[i] ? open_run[i] + 1 : 0;
                if (open_run[i] == DB + WD) begin
                    active[i]    = 1'b1;
                    muted[i]     = 1'b0;
                    open_run[i]  = 0;
                    close_run[i] = 0;
                end
            end else begin
`ifdef DOOR_WARN_STICKY_EN
                if (!muted[i]) begin
                    close_run[i] = 0;
                    if (av[i]) begin
                        if (!dv[i]) active[i] = 1'b0;
                        else        muted[i]  = 1'b1;
                    end
                end else
`endif
                begin
                    close_run[i] = dv[i] ? 0 : close_run[i] + 1;
                    if (close_run[i] == DB) begin
                        active[i]    = 1'b0;
                        muted[i]     = 1'b0;
                        close_run[i] = 0;
                    end else if (av[i]) begin
                        muted[i] = 1'b1;
                    end
                end
            end
            e.w[i] = active[i] && !muted[i];
            if (e.w[i]) cnt++;
        end
        e.a = (cnt != 0);
        e.c = CW'(cnt);
        return e;
    endfunction

    // Drive one edge worth of stimulus and queue its expected result.
    task automatic cycle(input logic [N-1:0] d, input logic [N-1:0] a);
        @(negedge clock);
        door_open = d;
        warn_ack  = a;
        q.push_back(model_step(d, a));
    endtask

    task automatic cycles(input int n, input logic [N-1:0] d, input logic [N-1:0] a);
        for (int k = 0; k < n; k++) cycle(d, a);
    endtask

    // Mid-cycle asynchronous reset; outputs must drop before any edge.
    task automatic async_reset(input string name);
        @(negedge clock);
        #2;
        reset     = 1'b1;
        door_open = '0;
        warn_ack  = '0;
        q.delete();
        model_reset();
        #1;
        check({name, "_warn"},  32'(warn_door_open), 32'd0);
        check({name, "_any"},   32'(warn_any),       32'd0);
        check({name, "_count"}, 32'(warn_count),     32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Monitor: compare DUT outputs against the queued expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (!reset && q.size() != 0) begin
                e = q.pop_front();
                check("warn_door_open", 32'(warn_door_open), 32'(e.w));
                check("warn_any",       32'(warn_any),       32'(e.a));
                check("warn_count",     32'(warn_count),     32'(e.c));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d entries pending", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int           hold[N];
        logic [N-1:0] dv;
        logic [N-1:0] av;

        reset     = 1'b1;
        door_open = '0;
        warn_ack  = '0;
        model_reset();
        #1;
        check("reset_warn",  32'(warn_door_open), 32'd0);
        check("reset_any",   32'(warn_any),       32'd0);
        check("reset_count", 32'(warn_count),     32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Door 0 held open: warning after the full debounce + delay.
        for (int k = 0; k < 120; k++) cycle(4'b0001, 4'($urandom) & 4'b1110);
        cycles(6, 4'b0000, 4'b0000);

        // Door 1 short glitch never warns.
        cycles(3, 4'b0010, 4'b0000);
        cycles(110, 4'b0000, 4'b0000);

        // Door 2: warn, acknowledge while open, close, reopen.
        cycles(104, 4'b0100, 4'b0000);
        cycle(4'b0100, 4'b0100);
        cycles(20, 4'b0100, 4'b0000);
        cycles(6, 4'b0000, 4'b0000);
        cycles(110, 4'b0100, 4'b0000);
        cycles(6, 4'b0000, 4'b0000);

        // All doors warning, then door 3 closes with a reopen glitch.
        cycles(110, 4'b1111, 4'b0000);
        cycles(2, 4'b0111, 4'b0000);
        cycle(4'b1111, 4'b0000);
        cycles(6, 4'b0111, 4'b0000);
        cycles(6, 4'b0000, 4'b0000);

        // Asynchronous reset mid-delay and mid-warning.
        cycles(50, 4'b0001, 4'b0000);
        async_reset("rst_open_wait");
        cycles(110, 4'b0001, 4'b0000);
        async_reset("rst_warn");
        cycles(110, 4'b0001, 4'b0000);
        cycles(10, 4'b0000, 4'b0000);

        // Acknowledge with the door closed.
        cycles(110, 4'b0001, 4'b0000);
        cycles(2, 4'b0000, 4'b0000);
        cycle(4'b0000, 4'b0001);
        cycles(10, 4'b0000, 4'b0000);

        // Random long/short open and close runs with sporadic acknowledges.
        for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 200);
        dv = '0;
        for (int k = 0; k < 2500; k++) begin
            for (int i = 0; i < N; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    dv[i]   = ~dv[i];
                    hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6)
                                                          : $urandom_range(20, 220);
                end
                av[i] = ($urandom_range(0, 24) == 0);
            end
            cycle(dv, av);
        end
        cycles(12, 4'b0000, 4'b1111);

        @(posedge clock);
        @(posedge clock);
        #2;
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
